// File: rtl/game_pkg.sv
// Shared arena-game constants and the projectile slot record.
package game_pkg;

  localparam int COORD_W_DEFAULT = 10;
  localparam int SCREEN_W        = 640;
  localparam int SCREEN_H        = 480;

  // One projectile: live flag, travel direction (1 = right) and top-left corner.
  typedef struct packed {
    logic                       valid;
    logic                       dir;
    logic [COORD_W_DEFAULT-1:0] x;
    logic [COORD_W_DEFAULT-1:0] y;
  } proj_slot_t;

endpackage

// File: rtl/projectile_pool_if.sv
// Bus between player/keycode logic, boss health logic, colour mapper and the projectile pool.
interface projectile_pool_if #(
  parameter int NUM_SLOTS = 4,
  parameter int COORD_W   = 10
);

  logic                 vs_in;
  logic                 enable;
  logic                 fire;
  logic [COORD_W-1:0]   fire_x;
  logic [COORD_W-1:0]   fire_y;
  logic                 fire_dir;
  logic [COORD_W-1:0]   target_x;
  logic [COORD_W-1:0]   target_y;
  logic [COORD_W-1:0]   target_s;
  logic [COORD_W-1:0]   DrawX;
  logic [COORD_W-1:0]   DrawY;
  logic                 is_bullet;
  logic [NUM_SLOTS-1:0] slot_valid;
  logic                 hit_pulse;
  logic [7:0]           hit_count;
  logic                 busy;

  // Game side: drives requests, target and pixel position, observes the pool.
  modport master (
    output vs_in, enable, fire, fire_x, fire_y, fire_dir,
    output target_x, target_y, target_s, DrawX, DrawY,
    input  is_bullet, slot_valid, hit_pulse, hit_count, busy
  );

  // Pool side.
  modport slave (
    input  vs_in, enable, fire, fire_x, fire_y, fire_dir,
    input  target_x, target_y, target_s, DrawX, DrawY,
    output is_bullet, slot_valid, hit_pulse, hit_count, busy
  );

endinterface

// File: rtl/box_overlap.sv
// Combinational overlap test between a square of edge a_s at (ax, ay) and a
// reference point (bx, by) widened by b_lo on the low side and b_hi on the high side.
// Written without subtraction so nothing underflows near the screen origin.
module box_overlap #(
  parameter int W = 10
) (
  input  logic [W-1:0] ax,
  input  logic [W-1:0] ay,
  input  logic [W-1:0] a_s,
  input  logic [W-1:0] bx,
  input  logic [W-1:0] by,
  input  logic [W-1:0] b_lo,
  input  logic [W-1:0] b_hi,
  output logic         hit
);

  // Two guard bits keep the three-term sums from wrapping.
  logic [W+1:0] ax_e, ay_e, as_e, bx_e, by_e, lo_e, hi_e;

  assign ax_e = {2'b00, ax};
  assign ay_e = {2'b00, ay};
  assign as_e = {2'b00, a_s};
  assign bx_e = {2'b00, bx};
  assign by_e = {2'b00, by};
  assign lo_e = {2'b00, b_lo};
  assign hi_e = {2'b00, b_hi};

  // Both axes must overlap.
  always_comb begin
    hit = (ax_e + as_e + lo_e > bx_e) && (ax_e < bx_e + hi_e) &&
          (ay_e + as_e + lo_e > by_e) && (ay_e < by_e + hi_e);
  end

endmodule

// File: rtl/projectile_pool.sv
// Pool of player projectiles: spawn with cooldown, per-frame move/retire/hit scan,
// and a registered per-pixel occupancy flag for the colour mapper.
module projectile_pool
  import game_pkg::*;
#(
  parameter int NUM_SLOTS = 4,
  parameter int COORD_W   = COORD_W_DEFAULT,
  parameter int SPEED     = 4,
  parameter int BULLET_S  = 4,
  parameter int SCREEN_W  = game_pkg::SCREEN_W,
  parameter int COOLDOWN  = 8
) (
  input logic              Clk,
  input logic              Reset,
  projectile_pool_if.slave bus
);

  localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int CD_W  = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SCAN  = 2'd1;
  localparam logic [1:0] ST_SPAWN = 2'd2;

  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_SLOTS - 1);
  localparam logic [COORD_W-1:0] SPEED_C  = COORD_W'(SPEED);
  localparam logic [COORD_W-1:0] BULLET_C = COORD_W'(BULLET_S);
  localparam logic [COORD_W-1:0] ZERO_C   = '0;
  localparam logic [COORD_W-1:0] ONE_C    = COORD_W'(1);
  localparam logic [COORD_W+1:0] SPEED_E  = (COORD_W + 2)'(SPEED);
  localparam logic [COORD_W+1:0] SCREEN_E = (COORD_W + 2)'(SCREEN_W);

  logic [2:0]                       vs_sync_q, vs_sync_d;
  logic [1:0]                       state_q, state_d;
  logic [IDX_W-1:0]                 idx_q, idx_d;
  proj_slot_t [NUM_SLOTS-1:0]       slots_q, slots_d;
  logic [CD_W-1:0]                  cool_q, cool_d;
  logic                             fire_req_q, fire_req_d;
  logic [COORD_W-1:0]               fire_x_q, fire_x_d, fire_y_q, fire_y_d;
  logic                             fire_dir_q, fire_dir_d;
  logic                             hit_pulse_q, hit_pulse_d;
  logic [7:0]                       hit_count_q, hit_count_d;
  logic                             is_bullet_q, is_bullet_d;

  logic                             frame_tick;
  proj_slot_t                       cur;
  logic [COORD_W-1:0]               moved_x;
  logic                             at_edge;
  logic                             coll_hit;
  logic                             free_found;
  logic [IDX_W-1:0]                 free_idx;
  logic [NUM_SLOTS-1:0]             pix_hit;
  logic [NUM_SLOTS-1:0]             valid_vec;

  // vs_in crosses into Clk through two flops; the third flop gives the edge detector its history.
  assign vs_sync_d  = {vs_sync_q[1:0], bus.vs_in};
  assign frame_tick = vs_sync_q[1] & ~vs_sync_q[2];

  // The slot under the scan pointer, its candidate position and the screen-edge test.
  assign cur     = slots_q[idx_q];
  assign moved_x = cur.dir ? (cur.x + SPEED_C) : (cur.x - SPEED_C);
  assign at_edge = cur.dir ? ({2'b00, cur.x} + SPEED_E >= SCREEN_E) : (cur.x < SPEED_C);

  // Collision uses the target box expanded by target_s on both sides of its centre.
  box_overlap #(.W(COORD_W)) u_hit (
    .ax(moved_x), .ay(cur.y), .a_s(BULLET_C),
    .bx(bus.target_x), .by(bus.target_y),
    .b_lo(bus.target_s), .b_hi(bus.target_s),
    .hit(coll_hit)
  );

  // One point-in-square test per slot for the pixel query.
  generate
    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_pix
      box_overlap #(.W(COORD_W)) u_pix (
        .ax(slots_q[gi].x), .ay(slots_q[gi].y), .a_s(BULLET_C),
        .bx(bus.DrawX), .by(bus.DrawY),
        .b_lo(ZERO_C), .b_hi(ONE_C),
        .hit(pix_hit[gi])
      );
      assign valid_vec[gi] = slots_q[gi].valid;
    end
  endgenerate

  // Lowest-index free slot for spawning.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!slots_q[i].valid) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  // Fire latch, frame FSM, slot update, hit accounting and pixel flag.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    slots_d     = slots_q;
    cool_d      = cool_q;
    fire_req_d  = fire_req_q;
    fire_x_d    = fire_x_q;
    fire_y_d    = fire_y_q;
    fire_dir_d  = fire_dir_q;
    hit_pulse_d = 1'b0;
    hit_count_d = hit_count_q;
    is_bullet_d = |(valid_vec & pix_hit);

    // Coordinates are frozen at the first request cycle of the frame.
    if (bus.fire && bus.enable) begin
      fire_req_d = 1'b1;
      if (!fire_req_q) begin
        fire_x_d   = bus.fire_x;
        fire_y_d   = bus.fire_y;
        fire_dir_d = bus.fire_dir;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (frame_tick) begin
          state_d = ST_SCAN;
          idx_d   = '0;
        end
      end
      ST_SCAN: begin
        if (cur.valid) begin
          if (!bus.enable) begin
            slots_d[idx_q] = '0;
          end else if (at_edge) begin
            slots_d[idx_q].valid = 1'b0;
          end else if (coll_hit) begin
            slots_d[idx_q].valid = 1'b0;
            hit_pulse_d          = 1'b1;
            if (hit_count_q != 8'hFF) begin
              hit_count_d = hit_count_q + 8'd1;
            end
          end else begin
            slots_d[idx_q].x = moved_x;
          end
        end
        if (idx_q == LAST_IDX) begin
          state_d = ST_SPAWN;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_SPAWN: begin
        state_d    = ST_IDLE;
        fire_req_d = 1'b0;
        if (!bus.enable) begin
          cool_d = '0;
        end else if (cool_q != '0) begin
          cool_d = cool_q - CD_W'(1);
        end else if (fire_req_q && free_found) begin
          slots_d[free_idx].valid = 1'b1;
          slots_d[free_idx].dir   = fire_dir_q;
          slots_d[free_idx].x     = fire_x_q;
          slots_d[free_idx].y     = fire_y_q;
          cool_d                  = CD_W'(COOLDOWN);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      vs_sync_q   <= '0;
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      slots_q     <= '0;
      cool_q      <= '0;
      fire_req_q  <= 1'b0;
      fire_x_q    <= '0;
      fire_y_q    <= '0;
      fire_dir_q  <= 1'b0;
      hit_pulse_q <= 1'b0;
      hit_count_q <= '0;
      is_bullet_q <= 1'b0;
    end else begin
      vs_sync_q   <= vs_sync_d;
      state_q     <= state_d;
      idx_q       <= idx_d;
      slots_q     <= slots_d;
      cool_q      <= cool_d;
      fire_req_q  <= fire_req_d;
      fire_x_q    <= fire_x_d;
      fire_y_q    <= fire_y_d;
      fire_dir_q  <= fire_dir_d;
      hit_pulse_q <= hit_pulse_d;
      hit_count_q <= hit_count_d;
      is_bullet_q <= is_bullet_d;
    end
  end

  assign bus.is_bullet  = is_bullet_q;
  assign bus.slot_valid = valid_vec;
  assign bus.hit_pulse  = hit_pulse_q;
  assign bus.hit_count  = hit_count_q;
  assign bus.busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_projectile_pool.sv
// Self-checking bench for projectile_pool: directed frame sequences, a pixel-query
// vector table, and randomized frames against a frame-level reference model.
module tb_projectile_pool;

  localparam int NS = 4;
  localparam int CW = 10;

  logic Clk = 1'b0;
  logic Reset;

  always #10 Clk = ~Clk;

  projectile_pool_if #(.NUM_SLOTS(NS), .COORD_W(CW)) bus ();

  projectile_pool #(
    .NUM_SLOTS(NS), .COORD_W(CW), .SPEED(4), .BULLET_S(4),
    .SCREEN_W(640), .COOLDOWN(8)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int dx;
    int dy;
    bit exp;
  } pix_vec_t;

  pix_vec_t pix_tab[8];

  // Frame-level reference model state.
  bit m_valid[NS];
  bit m_dir[NS];
  int m_x[NS];
  int m_y[NS];
  int m_cool, m_hits;
  bit m_req, m_fd;
  int m_fx, m_fy;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
  endtask

  task automatic set_target(input int tx, input int ty, input int ts);
    bus.target_x = CW'(tx);
    bus.target_y = CW'(ty);
    bus.target_s = CW'(ts);
  endtask

  task automatic fire_pulse(input int x, input int y, input bit d);
    @(negedge Clk);
    bus.fire = 1'b1; bus.fire_x = CW'(x); bus.fire_y = CW'(y); bus.fire_dir = d;
    @(negedge Clk);
    bus.fire = 1'b0;
  endtask

  // Raise vs_in, wait for the scan to start and finish, count hit_pulse cycles.
  task automatic do_frame(output int pulses);
    bit seen_busy;
    bit done;
    pulses = 0; seen_busy = 0; done = 0;
    bus.vs_in = 1'b1;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge Clk);
      if (bus.hit_pulse) pulses++;
      if (bus.busy) seen_busy = 1;
      else if (seen_busy) done = 1;
    end
    if (!done) check("frame_timeout", 32'(seen_busy), 32'd2);
    bus.vs_in = 1'b0;
    repeat (3) @(negedge Clk);
  endtask

  task automatic query(input int x, input int y, output logic r);
    @(negedge Clk);
    bus.DrawX = CW'(x); bus.DrawY = CW'(y);
    @(negedge Clk);
    r = bus.is_bullet;
  endtask

  function automatic void m_reset();
    for (int i = 0; i < NS; i++) begin
      m_valid[i] = 0; m_dir[i] = 0; m_x[i] = 0; m_y[i] = 0;
    end
    m_cool = 0; m_hits = 0; m_req = 0; m_fd = 0; m_fx = 0; m_fy = 0;
  endfunction

  function automatic void m_fire(input int x, input int y, input bit d, input bit en);
    if (en) begin
      if (!m_req) begin m_fx = x; m_fy = y; m_fd = d; end
      m_req = 1;
    end
  endfunction

  function automatic int m_frame(input bit en, input int tx, input int ty, input int ts);
    int hits = 0;
    int nx;
    for (int i = 0; i < NS; i++) begin
      if (m_valid[i]) begin
        if (!en) m_valid[i] = 0;
        else if (m_dir[i] && m_x[i] + 4 >= 640) m_valid[i] = 0;
        else if (!m_dir[i] && m_x[i] < 4) m_valid[i] = 0;
        else begin
          nx = m_dir[i] ? m_x[i] + 4 : m_x[i] - 4;
          if (nx + 4 + ts > tx && nx < tx + ts && m_y[i] + 4 + ts > ty && m_y[i] < ty + ts) begin
            m_valid[i] = 0;
            hits++;
          end else m_x[i] = nx;
        end
      end
    end
    m_hits = (m_hits + hits > 255) ? 255 : m_hits + hits;
    if (!en) m_cool = 0;
    else if (m_cool > 0) m_cool--;
    else if (m_req) begin
      for (int i = 0; i < NS; i++) begin
        if (!m_valid[i]) begin
          m_valid[i] = 1; m_dir[i] = m_fd; m_x[i] = m_fx; m_y[i] = m_fy;
          m_cool = 8;
          break;
        end
      end
    end
    m_req = 0;
    return hits;
  endfunction

  function automatic logic [NS-1:0] m_vec();
    logic [NS-1:0] v;
    for (int i = 0; i < NS; i++) v[i] = m_valid[i];
    return v;
  endfunction

  function automatic bit m_pixel(input int px, input int py);
    bit r = 0;
    for (int i = 0; i < NS; i++)
      if (m_valid[i] && px >= m_x[i] && px < m_x[i] + 4 && py >= m_y[i] && py < m_y[i] + 4) r = 1;
    return r;
  endfunction

  initial begin
    #10ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p, tot, prev, nsp, k, px, py, hits, tx, ty, ts;
    int spawn_fr[$];
    logic r;
    bit en, c100;

    Reset = 1'b0;
    bus.vs_in = 0; bus.enable = 1; bus.fire = 0;
    bus.fire_x = '0; bus.fire_y = '0; bus.fire_dir = 0;
    bus.DrawX = '0; bus.DrawY = '0;
    set_target(0, 0, 0);
    #3 Reset = 1'b1;
    #1;
    check("async_reset_busy", 32'(bus.busy), 32'd0);
    do_reset();

    // ---- Test 1: reset state, spawn, one move, pixel table ----
    check("rst_slot_valid", 32'(bus.slot_valid), 32'd0);
    check("rst_hit_pulse", 32'(bus.hit_pulse), 32'd0);
    check("rst_hit_count", 32'(bus.hit_count), 32'd0);
    check("rst_is_bullet", 32'(bus.is_bullet), 32'd0);
    // Second request cycle carries different coordinates; the first must win.
    @(negedge Clk);
    bus.fire = 1; bus.fire_x = 100; bus.fire_y = 200; bus.fire_dir = 1;
    @(negedge Clk);
    bus.fire_x = 50; bus.fire_y = 50; bus.fire_dir = 0;
    @(negedge Clk);
    bus.fire = 0;
    do_frame(p);
    check("t1_spawn_valid", 32'(bus.slot_valid), 32'h1);
    query(100, 200, r);
    check("t1_pix_spawn", 32'(r), 32'd1);
    query(50, 50, r);
    check("t1_pix_second_coords", 32'(r), 32'd0);
    do_frame(p);
    pix_tab[0] = '{103, 200, 0};
    pix_tab[1] = '{104, 200, 1};
    pix_tab[2] = '{107, 203, 1};
    pix_tab[3] = '{108, 200, 0};
    pix_tab[4] = '{104, 204, 0};
    pix_tab[5] = '{104, 199, 0};
    pix_tab[6] = '{105, 202, 1};
    pix_tab[7] = '{100, 200, 0};
    foreach (pix_tab[i]) begin
      query(pix_tab[i].dx, pix_tab[i].dy, r);
      check($sformatf("t1_pix_%0d_%0d", pix_tab[i].dx, pix_tab[i].dy), 32'(r), 32'(pix_tab[i].exp));
    end

    // ---- Test 2: held fire, cooldown spacing, pool full ----
    do_reset();
    bus.fire = 1; bus.fire_x = 20; bus.fire_y = 300; bus.fire_dir = 1;
    prev = 0; tot = 0;
    for (int f = 1; f <= 40; f++) begin
      do_frame(p);
      tot += p;
      nsp = $countones(bus.slot_valid);
      if (nsp > prev) spawn_fr.push_back(f);
      prev = nsp;
    end
    bus.fire = 0;
    check("t2_spawn_count", 32'(spawn_fr.size()), 32'd4);
    for (int i = 0; i < 4 && i < spawn_fr.size(); i++)
      check($sformatf("t2_spawn_frame_%0d", i), 32'(spawn_fr[i]), 32'(1 + 9 * i));
    check("t2_full", 32'(bus.slot_valid), 32'hF);
    check("t2_no_hits", 32'(tot), 32'd0);

    // ---- Test 3: screen edges ----
    do_reset();
    fire_pulse(636, 50, 1);
    do_frame(p);
    check("t3_636_spawned", 32'(bus.slot_valid), 32'h1);
    do_frame(p);
    check("t3_636_retired", 32'(bus.slot_valid), 32'h0);
    check("t3_636_no_pulse", 32'(p), 32'd0);
    do_reset();
    fire_pulse(635, 50, 1);
    do_frame(p);
    do_frame(p);
    check("t3_635_alive", 32'(bus.slot_valid), 32'h1);
    query(639, 50, r);
    check("t3_635_at_639", 32'(r), 32'd1);
    do_frame(p);
    check("t3_639_retired", 32'(bus.slot_valid), 32'h0);
    do_reset();
    fire_pulse(3, 60, 0);
    do_frame(p);
    check("t3_x3_spawned", 32'(bus.slot_valid), 32'h1);
    do_frame(p);
    check("t3_x3_retired", 32'(bus.slot_valid), 32'h0);

    // ---- Test 4: two hits in one frame ----
    do_reset();
    set_target(300, 100, 20);
    fire_pulse(240, 96, 1);
    do_frame(p);
    tot = 0;
    for (int f = 0; f < 8; f++) begin do_frame(p); tot += p; end
    fire_pulse(276, 110, 1);
    do_frame(p);
    tot += p;
    check("t4_no_early_hit", 32'(tot), 32'd0);
    check("t4_two_live", 32'(bus.slot_valid), 32'h3);
    query(276, 96, r);
    check("t4_pix_a", 32'(r), 32'd1);
    do_frame(p);
    check("t4_pulse_cycles", 32'(p), 32'd2);
    check("t4_hit_count", 32'(bus.hit_count), 32'd2);
    check("t4_slots_clear", 32'(bus.slot_valid), 32'h0);

    // ---- Test 5: enable low clears, fire ignored, hit_count saturates ----
    do_reset();
    set_target(0, 0, 0);
    for (int f = 1; f <= 19; f++) begin
      if (f == 1 || f == 10 || f == 19) fire_pulse(40 * f, 150, 1);
      do_frame(p);
    end
    check("t5_three_live", 32'(bus.slot_valid), 32'h7);
    @(negedge Clk); bus.enable = 0;
    fire_pulse(200, 200, 1);
    do_frame(p);
    check("t5_disable_clears", 32'(bus.slot_valid), 32'h0);
    @(negedge Clk); bus.enable = 1;
    do_frame(p);
    check("t5_fire_ignored", 32'(bus.slot_valid), 32'h0);
    set_target(300, 100, 20);
    bus.fire = 1; bus.fire_x = 280; bus.fire_y = 100; bus.fire_dir = 1;
    tot = 0; c100 = 0;
    for (int f = 0; f < 3000 && tot < 300; f++) begin
      do_frame(p);
      tot += p;
      if (tot == 100 && !c100) begin
        c100 = 1;
        check("t5_count_100", 32'(bus.hit_count), 32'd100);
      end
    end
    bus.fire = 0;
    check("t5_total_pulses", 32'(tot), 32'd300);
    check("t5_saturated", 32'(bus.hit_count), 32'd255);

    // ---- Test 6: reset in the middle of a scan ----
    @(negedge Clk); bus.enable = 0;
    do_frame(p);
    @(negedge Clk); bus.enable = 1;
    fire_pulse(100, 300, 1);
    do_frame(p);
    check("t6_live_before", 32'(bus.slot_valid), 32'h1);
    bus.DrawX = 106; bus.DrawY = 301;
    bus.vs_in = 1;
    k = 0;
    while (!bus.busy && k < 20) begin @(negedge Clk); k++; end
    check("t6_busy_seen", 32'(bus.busy), 32'd1);
    repeat (2) @(negedge Clk);
    check("t6_pix_before_rst", 32'(bus.is_bullet), 32'd1);
    #2 Reset = 1;
    #1;
    check("t6_rst_valid", 32'(bus.slot_valid), 32'h0);
    check("t6_rst_busy", 32'(bus.busy), 32'd0);
    check("t6_rst_count", 32'(bus.hit_count), 32'd0);
    check("t6_rst_pulse", 32'(bus.hit_pulse), 32'd0);
    check("t6_rst_pix", 32'(bus.is_bullet), 32'd0);
    bus.vs_in = 0;
    repeat (3) @(negedge Clk);
    Reset = 0;
    @(negedge Clk);
    do_frame(p);
    check("t6_clean_pulses", 32'(p), 32'd0);
    check("t6_clean_valid", 32'(bus.slot_valid), 32'h0);
    check("t6_clean_count", 32'(bus.hit_count), 32'd0);

    // ---- Randomized frames against the reference model ----
    do_reset();
    m_reset();
    tx = 320; ty = 240; ts = 30;
    for (int f = 0; f < 150; f++) begin
      if (f % 40 == 0) begin
        tx = $urandom_range(100, 540); ty = $urandom_range(60, 420); ts = $urandom_range(5, 40);
        set_target(tx, ty, ts);
      end
      en = ($urandom_range(0, 9) != 0);
      @(negedge Clk); bus.enable = en;
      if ($urandom_range(0, 1) == 1) begin
        if ($urandom_range(0, 1) == 1) begin
          px = tx - 60 + $urandom_range(0, 40); py = ty - 20 + $urandom_range(0, 40);
        end else begin
          px = $urandom_range(0, 639); py = $urandom_range(0, 475);
        end
        k = $urandom_range(0, 1);
        fire_pulse(px, py, k[0]);
        m_fire(px, py, k[0], en);
      end
      do_frame(p);
      hits = m_frame(en, tx, ty, ts);
      check($sformatf("rnd%0d_pulses", f), 32'(p), 32'(hits));
      check($sformatf("rnd%0d_valid", f), 32'(bus.slot_valid), 32'(m_vec()));
      check($sformatf("rnd%0d_count", f), 32'(bus.hit_count), 32'(m_hits));
      k = $urandom_range(0, NS - 1);
      px = m_x[k] + $urandom_range(0, 5) - 1; py = m_y[k] + $urandom_range(0, 5) - 1;
      if (px < 0) px = 0;
      if (py < 0) py = 0;
      query(px, py, r);
      check($sformatf("rnd%0d_pix_%0d_%0d", f, px, py), 32'(r), 32'(m_pixel(px, py)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/projectile_pool.md
Name: projectile_pool

Overview:
Manages a pool of NUM_SLOTS independent player projectiles for the arena game. This replaces the single bulletX/bulletY pair previously embedded in the player logic.
- Spawns a projectile on a fire request, subject to a frame cooldown.
- Advances every live projectile once per video frame.
- Retires projectiles that leave the screen or hit the target box (the boss), and reports hits.
- Answers per-pixel "is projectile" queries for the colour mapper.
- Sits between the keycode/player logic and both the boss health logic and the ColorMapper.

Parameters:
- NUM_SLOTS, 4, number of projectile slots (1..16)
- COORD_W, 10, coordinate width in bits
- SPEED, 4, pixels moved per frame
- BULLET_S, 4, projectile square edge in pixels
- SCREEN_W, 640, horizontal extent; x positions are 0..SCREEN_W-1
- COOLDOWN, 8, minimum number of frames between spawns

Ports:
- Clk, in, 1, 50 MHz system clock
- Reset, in, 1, asynchronous, active-high
- vs_in, in, 1, VGA vertical sync level; its rising edge marks a frame
- enable, in, 1, gameplay active (low while in menu or game_over)
- fire, in, 1, fire request level
- fire_x, in, COORD_W, spawn x (top-left corner)
- fire_y, in, COORD_W, spawn y (top-left corner)
- fire_dir, in, 1, 0 = moving left, 1 = moving right
- target_x, in, COORD_W, target centre x
- target_y, in, COORD_W, target centre y
- target_s, in, COORD_W, target half-size
- DrawX, in, COORD_W, pixel x being drawn
- DrawY, in, COORD_W, pixel y being drawn
- is_bullet, out, 1, registered pixel-hit flag
- slot_valid, out, NUM_SLOTS, live flag per slot
- hit_pulse, out, 1, one-Clk pulse per target hit
- hit_count, out, 8, saturating total of hits
- busy, out, 1, frame update in progress

Behaviour:
Reset:
- All slots invalid; x and y registers cleared to 0.
- is_bullet = 0, hit_pulse = 0, hit_count = 0, busy = 0.
- cooldown = 0, fire latch cleared, FSM in IDLE.
- Reset is asynchronous and acts immediately, including mid-scan.

Frame detection:
- vs_in passes through a 2-flop synchroniser, then a rising-edge detector.
- frame_tick is a single Clk pulse.

Fire latch:
- fire_req is set on any Clk cycle with fire = 1 and enable = 1.
- fire_x, fire_y and fire_dir are captured on the first set cycle only.
- fire_req clears on leaving SPAWN.

FSM:
- IDLE: waits for frame_tick, then goes to SCAN with idx = 0 and busy = 1.
- SCAN: one slot per Clk; idx increments; after idx = NUM_SLOTS-1 goes to SPAWN. Per valid slot:
  - If enable = 0: slot is cleared.
  - Else if dir = 1 and x + SPEED >= SCREEN_W: retire.
  - Else if dir = 0 and x < SPEED: retire. There is never any wrap-around.
  - Else x moves by ±SPEED. Collision is tested on the moved position:
    - x + BULLET_S + target_s > target_x, and x < target_x + target_s, and the same on y.
    - Comparisons are done at COORD_W+2 bits unsigned.
  - On collision: the slot retires, hit_pulse = 1 on that same cycle, and hit_count increments (it holds at 255).
- SPAWN: single cycle, then goes to IDLE with busy = 0.
  - If enable = 0: cooldown = 0 and no spawn.
  - Else if cooldown > 0: cooldown decrements and no spawn.
  - Else if fire_req and a free slot exists: the lowest-index free slot loads the latched coordinates and dir; cooldown = COOLDOWN.
  - Else if no slot is free: the request is dropped and cooldown is left unchanged.
- frame_tick while busy: ignored. Worst-case busy time is NUM_SLOTS+1 cycles, far shorter than a frame.
- Multiple hits in one frame give one hit_pulse per hitting slot, on distinct cycles.

Pixel query:
- is_bullet is registered and valid 1 Clk after DrawX/DrawY.
- It is 1 if any valid slot has x <= DrawX < x + BULLET_S and y <= DrawY < y + BULLET_S.
- It reads slot state as of the previous cycle; a tear during SCAN is acceptable.

Decomposition:
- Package game_pkg: COORD_W default, SCREEN_W, SCREEN_H, and typedef proj_slot_t {valid, dir, x, y}.
- Sub-module box_overlap: combinational AABB test, reused for both the collision test and the pixel query.

Test Plan:
1. Reset, then fire = 1 with (100, 200, dir = 1) for 1 Clk, then one frame -> slot_valid = 0001; after the next frame slot 0 x = 104.
2. fire held for 40 frames with COOLDOWN = 8 -> spawns occur 9 frames apart; after 4 live, further fires are dropped and slot_valid stays 1111.
3. Slot at x = 636, dir = 1 -> retired on the next frame with no hit_pulse. Slot at x = 3, dir = 0 -> retired on the next frame.
4. Target (300, 100, s = 20); two slots at x = 276, y = 96 and x = 276, y = 110, dir = 1 -> two distinct hit_pulse cycles, hit_count = 2, both slots invalid.
5. enable = 0 with 3 live slots -> all cleared next frame; fire ignored; hit_count holds 255 after 300 hits.
6. Reset asserted mid-SCAN (idx = 2) -> all outputs reset immediately; the next frame performs a clean scan with no spurious hit.
